// File: rtl/fp_pkg.sv
// Shared FP definitions: funct5 codes, tag/ROB widths and issue-queue entry layout.
package fp_pkg;

   localparam logic [4:0]  FADDS   = 5'b00000;
   localparam logic [4:0]  FSUBS   = 5'b00001;

   localparam int unsigned TAG_W   = 7;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned ROB_LEN = 32;
   localparam int unsigned ROB_W   = $clog2(ROB_LEN);

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic              rdy;
      logic [DATA_W-1:0] val;
   } fiq_src_t;

   typedef struct packed {
      logic              valid;
      logic [4:0]        funct5;
      logic [ROB_W-1:0]  rob_idx;
      logic [TAG_W-1:0]  rd;
      fiq_src_t          src1;
      fiq_src_t          src2;
   } fiq_entry_t;

   // Capture a broadcast value into a source that is still waiting on that tag.
   function automatic fiq_src_t wake_src(input fiq_src_t          s,
                                         input logic              cv,
                                         input logic [TAG_W-1:0]  ct,
                                         input logic [DATA_W-1:0] cd);
      fiq_src_t r;
      r = s;
      if (!s.rdy && cv && (s.tag == ct)) begin
         r.rdy = 1'b1;
         r.val = cd;
      end
      return r;
   endfunction

endpackage

// File: rtl/fiq_oldest_ready_sel.sv
// Priority encoder: lowest-index set bit of the ready vector wins (slot 0 is oldest).
module fiq_oldest_ready_sel #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] ready,
   output logic [N-1:0] grant_c,
   output logic         found_c
);

   // First ready slot scanning upward from the oldest.
   always_comb begin
      grant_c = '0;
      found_c = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (ready[i] && !found_c) begin
            grant_c[i] = 1'b1;
            found_c    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/falu_issue_queue.sv
// Age-ordered collapsing issue queue feeding FADD.S/FSUB.S ops into the FALU.
module falu_issue_queue
   import fp_pkg::*;
#(
   parameter  int unsigned ENTRIES = 4,
   localparam int unsigned OCC_W   = $clog2(ENTRIES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              disp_valid,
   output logic              disp_ready,
   input  logic [4:0]        disp_funct5,
   input  logic [ROB_W-1:0]  disp_rob_idx,
   input  logic [TAG_W-1:0]  disp_rd,
   input  logic [TAG_W-1:0]  disp_src1_tag,
   input  logic [TAG_W-1:0]  disp_src2_tag,
   input  logic              disp_src1_rdy,
   input  logic              disp_src2_rdy,
   input  logic [31:0]       disp_src1_val,
   input  logic [31:0]       disp_src2_val,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [31:0]       cdb_data,
   input  logic              issue_stall,
   input  logic              flush,
   output logic              falu_i_valid,
   output logic [4:0]        falu_funct5,
   output logic [31:0]       operand1,
   output logic [31:0]       operand2,
   output logic [ROB_W-1:0]  falu_i_rob_idx,
   output logic [TAG_W-1:0]  falu_i_rd,
   output logic [OCC_W-1:0]  occupancy
);

   fiq_entry_t         entries_q [ENTRIES];
   fiq_entry_t         entries_d [ENTRIES];
   fiq_entry_t         woken     [ENTRIES];
   fiq_entry_t         disp_entry;
   logic [OCC_W-1:0]   occ_q;
   logic [OCC_W-1:0]   occ_d;
   logic [OCC_W-1:0]   wr_pos;
   logic [ENTRIES-1:0] ready_vec;
   logic [ENTRIES-1:0] grant;
   logic               found;
   logic               issue;
   logic               accept;
   logic               shift;

   // An entry is eligible once both operands have been captured.
   always_comb begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
         ready_vec[i] = entries_q[i].valid && entries_q[i].src1.rdy && entries_q[i].src2.rdy;
      end
   end

   fiq_oldest_ready_sel #(.N(ENTRIES)) u_sel (
      .ready   (ready_vec),
      .grant_c (grant),
      .found_c (found)
   );

   assign disp_ready   = (occ_q < OCC_W'(ENTRIES));
   assign issue        = found && !issue_stall && !flush;
   assign accept       = disp_valid && disp_ready && !flush;
   assign falu_i_valid = issue;
   assign occupancy    = occ_q;

   // Issue port carries the granted entry, zero when nothing issues.
   always_comb begin
      falu_funct5    = '0;
      operand1       = '0;
      operand2       = '0;
      falu_i_rob_idx = '0;
      falu_i_rd      = '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
         if (issue && grant[i]) begin
            falu_funct5    = entries_q[i].funct5;
            operand1       = entries_q[i].src1.val;
            operand2       = entries_q[i].src2.val;
            falu_i_rob_idx = entries_q[i].rob_idx;
            falu_i_rd      = entries_q[i].rd;
         end
      end
   end

   // Incoming op, with same-cycle CDB bypass into not-yet-ready sources.
   always_comb begin
      disp_entry         = '0;
      disp_entry.valid   = 1'b1;
      disp_entry.funct5  = disp_funct5;
      disp_entry.rob_idx = disp_rob_idx;
      disp_entry.rd      = disp_rd;
      disp_entry.src1    = wake_src(fiq_src_t'{disp_src1_tag, disp_src1_rdy, disp_src1_val},
                                    cdb_valid, cdb_tag, cdb_data);
      disp_entry.src2    = wake_src(fiq_src_t'{disp_src2_tag, disp_src2_rdy, disp_src2_val},
                                    cdb_valid, cdb_tag, cdb_data);
   end

   // Next queue image: wakeup, collapse over the issued slot, append, flush.
   always_comb begin
      shift  = 1'b0;
      occ_d  = occ_q;
      wr_pos = occ_q - OCC_W'(issue);
      for (int i = 0; i < int'(ENTRIES); i++) begin
         woken[i]      = entries_q[i];
         woken[i].src1 = wake_src(entries_q[i].src1, cdb_valid, cdb_tag, cdb_data);
         woken[i].src2 = wake_src(entries_q[i].src2, cdb_valid, cdb_tag, cdb_data);
         entries_d[i]  = woken[i];
      end
      for (int i = 0; i < int'(ENTRIES) - 1; i++) begin
         shift        = shift | grant[i];
         entries_d[i] = (issue && shift) ? woken[i+1] : woken[i];
      end
      entries_d[ENTRIES-1] = issue ? '0 : woken[ENTRIES-1];
      if (accept) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            if (OCC_W'(i) == wr_pos) begin
               entries_d[i] = disp_entry;
            end
         end
      end
      occ_d = occ_q - OCC_W'(issue) + OCC_W'(accept);
      if (flush) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            entries_d[i] = '0;
         end
         occ_d = '0;
      end
   end

   // Queue state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            entries_q[i] <= '0;
         end
         occ_q <= '0;
      end else begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            entries_q[i] <= entries_d[i];
         end
         occ_q <= occ_d;
      end
   end

endmodule

// File: tb/tb_falu_issue_queue.sv
// Self-checking bench: queue-based reference model plus directed literal checks.
module tb_falu_issue_queue;
   import fp_pkg::*;

   localparam int ENT = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              disp_valid, disp_ready;
   logic [4:0]        disp_funct5;
   logic [ROB_W-1:0]  disp_rob_idx;
   logic [TAG_W-1:0]  disp_rd, disp_src1_tag, disp_src2_tag;
   logic              disp_src1_rdy, disp_src2_rdy;
   logic [31:0]       disp_src1_val, disp_src2_val;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [31:0]       cdb_data;
   logic              issue_stall, flush;
   logic              falu_i_valid;
   logic [4:0]        falu_funct5;
   logic [31:0]       operand1, operand2;
   logic [ROB_W-1:0]  falu_i_rob_idx;
   logic [TAG_W-1:0]  falu_i_rd;
   logic [2:0]        occupancy;

   falu_issue_queue #(.ENTRIES(ENT)) dut (
      .clk(clk), .rst(rst),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_funct5(disp_funct5), .disp_rob_idx(disp_rob_idx), .disp_rd(disp_rd),
      .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
      .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
      .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .issue_stall(issue_stall), .flush(flush),
      .falu_i_valid(falu_i_valid), .falu_funct5(falu_funct5),
      .operand1(operand1), .operand2(operand2),
      .falu_i_rob_idx(falu_i_rob_idx), .falu_i_rd(falu_i_rd),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]       f5;
      logic [ROB_W-1:0] rob;
      logic [TAG_W-1:0] rd;
      logic [TAG_W-1:0] t1, t2;
      bit               r1, r2;
      logic [31:0]      v1, v2;
   } op_t;

   op_t q[$];
   int  n_chk  = 0;
   int  n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic int first_ready();
      for (int i = 0; i < q.size(); i++)
         if (q[i].r1 && q[i].r2) return i;
      return -1;
   endfunction

   task automatic compare_model();
      int  sel;
      bit  ev;
      sel = first_ready();
      ev  = (sel >= 0) && !issue_stall && !flush;
      chk("disp_ready", 32'(disp_ready), 32'(q.size() < ENT));
      chk("occupancy", 32'(occupancy), 32'(q.size()));
      chk("falu_i_valid", 32'(falu_i_valid), 32'(ev));
      if (ev) begin
         chk("funct5", 32'(falu_funct5), 32'(q[sel].f5));
         chk("operand1", operand1, q[sel].v1);
         chk("operand2", operand2, q[sel].v2);
         chk("rob_idx", 32'(falu_i_rob_idx), 32'(q[sel].rob));
         chk("rd", 32'(falu_i_rd), 32'(q[sel].rd));
      end else begin
         chk("idle_data", {27'(falu_funct5) | 32'(falu_i_rob_idx) | 32'(falu_i_rd)} | operand1 | operand2, 32'h0);
      end
   endtask

   task automatic update_model();
      int  sel;
      bit  acc;
      op_t e;
      if (flush) begin
         q.delete();
         return;
      end
      sel = issue_stall ? -1 : first_ready();
      acc = disp_valid && (q.size() < ENT);
      for (int i = 0; i < q.size(); i++) begin
         e = q[i];
         if (cdb_valid && !e.r1 && e.t1 == cdb_tag) begin e.r1 = 1; e.v1 = cdb_data; end
         if (cdb_valid && !e.r2 && e.t2 == cdb_tag) begin e.r2 = 1; e.v2 = cdb_data; end
         q[i] = e;
      end
      if (sel >= 0) q.delete(sel);
      if (acc) begin
         e.f5 = disp_funct5; e.rob = disp_rob_idx; e.rd = disp_rd;
         e.t1 = disp_src1_tag; e.r1 = disp_src1_rdy; e.v1 = disp_src1_val;
         e.t2 = disp_src2_tag; e.r2 = disp_src2_rdy; e.v2 = disp_src2_val;
         if (cdb_valid && !e.r1 && e.t1 == cdb_tag) begin e.r1 = 1; e.v1 = cdb_data; end
         if (cdb_valid && !e.r2 && e.t2 == cdb_tag) begin e.r2 = 1; e.v2 = cdb_data; end
         q.push_back(e);
      end
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic commit();
      compare_model();
      update_model();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      sample();
      commit();
   endtask

   task automatic idle();
      disp_valid = 0; disp_funct5 = 0; disp_rob_idx = 0; disp_rd = 0;
      disp_src1_tag = 0; disp_src2_tag = 0; disp_src1_rdy = 0; disp_src2_rdy = 0;
      disp_src1_val = 0; disp_src2_val = 0;
      cdb_valid = 0; cdb_tag = 0; cdb_data = 0; issue_stall = 0; flush = 0;
   endtask

   task automatic set_disp(input logic [TAG_W-1:0] rd,
                           input logic [TAG_W-1:0] t1, input bit r1, input logic [31:0] v1,
                           input logic [TAG_W-1:0] t2, input bit r2, input logic [31:0] v2);
      disp_valid = 1; disp_funct5 = FADDS; disp_rob_idx = ROB_W'(rd); disp_rd = rd;
      disp_src1_tag = t1; disp_src1_rdy = r1; disp_src1_val = v1;
      disp_src2_tag = t2; disp_src2_rdy = r2; disp_src2_val = v2;
   endtask

   initial begin
      idle();
      rst = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_disp_ready", 32'(disp_ready), 32'h1);
      chk("rst_occupancy", 32'(occupancy), 32'h0);
      chk("rst_valid", 32'(falu_i_valid), 32'h0);
      rst = 1;

      // Both-ready op issues the next cycle.
      set_disp(5, 1, 1, 32'h3F800000, 2, 1, 32'h40000000);
      step();
      idle();
      sample();
      chk("t1_valid", 32'(falu_i_valid), 32'h1);
      chk("t1_op1", operand1, 32'h3F800000);
      chk("t1_op2", operand2, 32'h40000000);
      chk("t1_rd", 32'(falu_i_rd), 32'd5);
      commit();
      sample();
      chk("t1_occ", 32'(occupancy), 32'h0);
      commit();

      // Younger ready op overtakes an older waiting op; wakeup then issues it.
      set_disp(10, 3, 1, 32'h1, 9, 0, 32'h0);
      step();
      set_disp(11, 4, 1, 32'h2, 6, 1, 32'h3);
      step();
      idle();
      sample();
      chk("t2_b_first", 32'(falu_i_rd), 32'd11);
      commit();
      cdb_valid = 1; cdb_tag = 9; cdb_data = 32'h40400000;
      step();
      idle();
      sample();
      chk("t2_a_valid", 32'(falu_i_valid), 32'h1);
      chk("t2_a_rd", 32'(falu_i_rd), 32'd10);
      chk("t2_a_op2", operand2, 32'h40400000);
      commit();

      // Full queue back-pressure.
      for (int i = 0; i < ENT; i++) begin
         set_disp(TAG_W'(30 + i), TAG_W'(20 + i), 0, 32'h0, 1, 1, 32'h5);
         step();
      end
      idle();
      sample();
      chk("t3_full_ready", 32'(disp_ready), 32'h0);
      chk("t3_full_occ", 32'(occupancy), 32'd4);
      commit();
      set_disp(40, 24, 0, 32'h0, 1, 1, 32'h5);
      step();
      idle();
      cdb_valid = 1; cdb_tag = 20; cdb_data = 32'h12345678;
      sample();
      chk("t3_no_accept", 32'(occupancy), 32'd4);
      commit();
      idle();
      sample();
      chk("t3_issue_rd", 32'(falu_i_rd), 32'd30);
      chk("t3_still_full", 32'(disp_ready), 32'h0);
      commit();
      sample();
      chk("t3_ready_again", 32'(disp_ready), 32'h1);
      commit();
      for (int i = 1; i < ENT; i++) begin
         cdb_valid = 1; cdb_tag = TAG_W'(20 + i); cdb_data = 32'(i);
         step();
      end
      idle();
      repeat (4) step();

      // Same-cycle CDB bypass on dispatch.
      set_disp(13, 12, 0, 32'h0, 2, 1, 32'h7);
      cdb_valid = 1; cdb_tag = 12; cdb_data = 32'hC0000000;
      step();
      idle();
      sample();
      chk("t4_valid", 32'(falu_i_valid), 32'h1);
      chk("t4_op1", operand1, 32'hC0000000);
      commit();

      // Stall holds every entry.
      for (int i = 0; i < 3; i++) begin
         set_disp(TAG_W'(50 + i), 1, 1, 32'(i), 2, 1, 32'h9);
         issue_stall = 1;
         step();
      end
      idle();
      issue_stall = 1;
      for (int i = 0; i < 2; i++) begin
         sample();
         chk("t5_stall_valid", 32'(falu_i_valid), 32'h0);
         chk("t5_stall_occ", 32'(occupancy), 32'd3);
         commit();
      end
      issue_stall = 0;
      sample();
      chk("t5_release_rd", 32'(falu_i_rd), 32'd50);
      commit();
      repeat (3) step();

      // Flush with a concurrent dispatch.
      for (int i = 0; i < 3; i++) begin
         set_disp(TAG_W'(60 + i), TAG_W'(70 + i), 0, 32'h0, 1, 1, 32'h1);
         step();
      end
      set_disp(63, 1, 1, 32'h1, 1, 1, 32'h1);
      flush = 1;
      sample();
      chk("t6_flush_valid", 32'(falu_i_valid), 32'h0);
      commit();
      idle();
      sample();
      chk("t6_occ", 32'(occupancy), 32'h0);
      chk("t6_valid", 32'(falu_i_valid), 32'h0);
      commit();

      // Asynchronous reset mid-operation.
      set_disp(70, 1, 1, 32'h11111111, 2, 1, 32'h22222222);
      issue_stall = 1;
      step();
      idle();
      sample();
      chk("t7_pre_valid", 32'(falu_i_valid), 32'h1);
      #1 rst = 0;
      #1;
      chk("t7_rst_valid", 32'(falu_i_valid), 32'h0);
      chk("t7_rst_op1", operand1, 32'h0);
      chk("t7_rst_rd", 32'(falu_i_rd), 32'h0);
      chk("t7_rst_occ", 32'(occupancy), 32'h0);
      q.delete();
      @(posedge clk);
      #1 rst = 1;

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         disp_valid    = ($urandom_range(0, 99) < 60);
         disp_funct5   = 5'($urandom);
         disp_rob_idx  = ROB_W'($urandom);
         disp_rd       = TAG_W'($urandom);
         disp_src1_tag = TAG_W'($urandom_range(0, 15));
         disp_src2_tag = TAG_W'($urandom_range(0, 15));
         disp_src1_rdy = ($urandom_range(0, 1) == 1);
         disp_src2_rdy = ($urandom_range(0, 1) == 1);
         disp_src1_val = $urandom;
         disp_src2_val = $urandom;
         cdb_valid     = ($urandom_range(0, 99) < 45);
         cdb_tag       = TAG_W'($urandom_range(0, 15));
         cdb_data      = $urandom;
         issue_stall   = ($urandom_range(0, 99) < 20);
         flush         = ($urandom_range(0, 99) < 2);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
